// File: rtl/merge_frame_sched_pkg.sv
// Shared types and constants for the frame scheduler in front of merge_cascade.
// Channel field layout must stay in step with the cascade.
package merge_frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } sched_state_t;

  // A triple carries its channel number in the top CH_SW bits.
  localparam int TRIPLE_DW = 32;
  localparam int CH_SW     = 8;

  // Pad frames carry an all-ones word.
  localparam logic PAD_FILL_BIT = 1'b1;

  function automatic int ch_lsb(input int dw, input int sw);
    return dw - sw;
  endfunction

endpackage

// File: rtl/rr_arbiter_ns.sv
// Round-robin request picker: first requester at or after ptr, wrapping at NS.
// Purely combinational; no state, no backpressure.
module rr_arbiter_ns #(
  parameter int NS  = 4,
  parameter int NSW = 2
) (
  input  logic [NS-1:0]  req,
  input  logic [NSW-1:0] ptr,
  output logic [NS-1:0]  gnt,
  output logic [NSW-1:0] idx,
  output logic           any
);

  logic [NSW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = ptr;
    for (int off = 0; off < NS; off++) begin
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
      // Explicit wrap so indices at or above NS are never visited.
      cand = (int'(cand) == NS - 1) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/merge_frame_sched.sv
// Round-robin whole-frame scheduler feeding merge_cascade, padding partial groups on flush.
// Zero-latency pass-through in XFER, one bubble per grant; o_ready stalls the granted source.
module merge_frame_sched
  import merge_frame_sched_pkg::*;
#(
  parameter int             DW       = TRIPLE_DW,
  parameter int             SW       = CH_SW,
  parameter int             THW      = 6,
  parameter int             NS       = 4,
  parameter int             NSW      = 2,
  parameter logic [DW-1:0]  PAD_WORD = {DW{PAD_FILL_BIT}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NS-1:0]    s_valid,
  input  logic [NS-1:0]    s_last,
  input  logic [NS*DW-1:0] s_data,
  output logic [NS-1:0]    s_ready,
  input  logic             o_ready,
  output logic             o_valid,
  output logic             o_last,
  output logic [DW-1:0]    o_data,
  input  logic             flush,
  output logic [THW-1:0]   o_fidx,
  output logic [NSW-1:0]   o_src,
  output logic             o_pad,
  output logic             group_done,
  output logic             busy
);

  if (NS < 2 || NS > 16 || (1 << NSW) < NS || THW < 1 || ch_lsb(DW, SW) < 1) begin : g_param_check
    $error("merge_frame_sched: illegal parameter combination");
  end

  sched_state_t   state, state_nxt;
  logic [NSW-1:0] ptr, src;
  logic [NS-1:0]  src_oh;
  logic [THW-1:0] fcnt;
  logic           flush_pend;

  logic [NS-1:0]  arb_gnt;
  logic [NSW-1:0] arb_idx;
  logic           arb_any;
  logic           frame_done;
  logic           fcnt_max;

  rr_arbiter_ns #(.NS(NS), .NSW(NSW)) u_arb (
    .req (s_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign fcnt_max   = &fcnt;
  assign frame_done = o_valid && o_ready && o_last;

  always_comb begin
    state_nxt = state;
    o_valid   = 1'b0;
    o_last    = 1'b0;
    o_data    = '0;
    s_ready   = '0;
    o_pad     = 1'b0;
    case (state)
      IDLE: begin
        // A pending flush outranks new grants so the open group is closed first.
        if (flush_pend) begin
          if (fcnt != '0) state_nxt = PAD;
        end else if (arb_any) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        o_valid = |(s_valid & src_oh);
        o_last  = |(s_last & src_oh);
        for (int k = 0; k < NS; k++) begin
          if (src_oh[k]) o_data = o_data | s_data[k*DW +: DW];
        end
        s_ready = o_ready ? src_oh : '0;
        if (o_valid && o_ready && o_last) state_nxt = IDLE;
      end
      PAD: begin
        o_valid = 1'b1;
        o_last  = 1'b1;
        o_data  = PAD_WORD;
        o_pad   = 1'b1;
        if (o_ready && fcnt_max) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      src        <= '0;
      src_oh     <= '0;
      fcnt       <= '0;
      flush_pend <= 1'b0;
      group_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      group_done <= frame_done && fcnt_max;
      if (frame_done) fcnt <= fcnt + 1'b1;
      if (state == IDLE && !flush_pend && arb_any) begin
        src    <= arb_idx;
        src_oh <= arb_gnt;
      end
      if (state == XFER && frame_done) ptr <= (int'(src) == NS - 1) ? '0 : src + 1'b1;
      // A new flush request wins over clearing, so it is never dropped.
      if (flush) begin
        flush_pend <= 1'b1;
      end else if (state == IDLE && flush_pend && fcnt == '0) begin
        flush_pend <= 1'b0;
      end else if (state == PAD && frame_done && fcnt_max) begin
        flush_pend <= 1'b0;
      end
    end
  end

  assign o_fidx = fcnt;
  assign o_src  = src;
  assign busy   = (state != IDLE) || flush_pend;

endmodule

// File: tb/tb_merge_frame_sched.sv
// Randomised bench for merge_frame_sched against a queue-based round-robin/group model.
module tb_merge_frame_sched;
  localparam int DW  = 32;
  localparam int SW  = 8;
  localparam int THW = 2;
  localparam int NS  = 4;
  localparam int NSW = 2;
  localparam int GRP = 1 << THW;
  localparam logic [DW-1:0] PADW = 32'hFFFF_FFFF;

  typedef struct packed {
    logic           pad;
    logic [NSW-1:0] src;
    logic [THW-1:0] fidx;
    logic           last;
    logic [DW-1:0]  data;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NS-1:0]    s_valid = '0;
  logic [NS-1:0]    s_last = '0;
  logic [NS*DW-1:0] s_data = '0;
  logic [NS-1:0]    s_ready;
  logic             o_ready = 1'b0;
  logic             o_valid, o_last;
  logic [DW-1:0]    o_data;
  logic             flush = 1'b0;
  logic [THW-1:0]   o_fidx;
  logic [NSW-1:0]   o_src;
  logic             o_pad, group_done, busy;

  merge_frame_sched #(.DW(DW), .SW(SW), .THW(THW), .NS(NS), .NSW(NSW), .PAD_WORD(PADW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_last(s_last), .s_data(s_data),
    .s_ready(s_ready), .o_ready(o_ready), .o_valid(o_valid), .o_last(o_last), .o_data(o_data),
    .flush(flush), .o_fidx(o_fidx), .o_src(o_src), .o_pad(o_pad), .group_done(group_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, gd_cnt = 0, gd_cyc = -1, first_pad_cyc = -1;
  int ready_mode = 0;
  logic [DW:0] q  [NS][$];
  logic [DW:0] mq [NS][$];
  beat_t obs[$], exp_q[$];
  int obs_cyc[$];
  int m_ptr = 0, m_fcnt = 0, m_src = 0, m_gd = 0;

  function automatic bit q_empty();
    for (int k = 0; k < NS; k++) if (q[k].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_src();
    logic [DW:0] w;
    for (int k = 0; k < NS; k++) begin
      if (q[k].size() > 0) begin
        w = q[k][0];
        s_valid[k] = 1'b1;
        s_last[k]  = w[DW];
        s_data[k*DW +: DW] = w[DW-1:0];
      end else begin
        s_valid[k] = 1'b0;
        s_last[k]  = 1'b0;
        s_data[k*DW +: DW] = '0;
      end
    end
  endtask

  task automatic cycle();
    logic [NS-1:0] acc;
    beat_t b;
    @(negedge clk);
    cyc++;
    if (o_valid && o_ready) begin
      b.pad = o_pad; b.src = o_src; b.fidx = o_fidx; b.last = o_last; b.data = o_data;
      obs.push_back(b);
      obs_cyc.push_back(cyc);
    end
    if (group_done) begin gd_cnt++; gd_cyc = cyc; end
    if (o_pad && first_pad_cyc < 0) first_pad_cyc = cyc;
    acc = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++) if (acc[k] && q[k].size() > 0) void'(q[k].pop_front());
    drive_src();
    case (ready_mode)
      0:       o_ready = 1'b1;
      1:       o_ready = ($urandom_range(0, 3) != 0);
      default: o_ready = !o_ready;
    endcase
    #1;
  endtask

  task automatic load_frame(input int s, input int len);
    logic [DW:0] w;
    for (int i = 0; i < len; i++) begin
      w[DW] = (i == len - 1);
      w[DW-1:0] = $urandom();
      q[s].push_back(w);
      mq[s].push_back(w);
    end
    drive_src();
  endtask

  // Reference: with all frames queued up front, frames leave in round-robin order,
  // one whole frame per grant, each bumping the frame-in-group counter.
  task automatic model_run();
    int g;
    logic [DW:0] w;
    beat_t b;
    for (int n = 0; n < 256; n++) begin
      g = -1;
      for (int off = 0; off < NS; off++)
        if (g < 0 && mq[(m_ptr + off) % NS].size() > 0) g = (m_ptr + off) % NS;
      if (g < 0) break;
      m_src = g;
      do begin
        w = mq[g].pop_front();
        b.pad = 1'b0; b.src = NSW'(g); b.fidx = THW'(m_fcnt); b.last = w[DW]; b.data = w[DW-1:0];
        exp_q.push_back(b);
      end while (!w[DW] && mq[g].size() > 0);
      m_fcnt = (m_fcnt + 1) % GRP;
      if (m_fcnt == 0) m_gd++;
      m_ptr = (g + 1) % NS;
    end
  endtask

  task automatic model_flush();
    beat_t b;
    for (int n = 0; n < GRP && m_fcnt != 0; n++) begin
      b.pad = 1'b1; b.src = NSW'(m_src); b.fidx = THW'(m_fcnt); b.last = 1'b1; b.data = PADW;
      exp_q.push_back(b);
      m_fcnt = (m_fcnt + 1) % GRP;
      if (m_fcnt == 0) m_gd++;
    end
  endtask

  task automatic run_until(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(obs.size() >= exp_q.size() && !busy && q_empty())) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s timeout: saw %0d beats, expected %0d", name, obs.size(), exp_q.size());
    end
    cycle();
    cycle();
  endtask

  task automatic clear_obs();
    obs.delete(); exp_q.delete(); obs_cyc.delete();
    first_pad_cyc = -1;
  endtask

  task automatic test_reset();
    ready_mode = 0;
    for (int k = 0; k < NS; k++) load_frame(k, 2);
    cycle(); cycle();
    checks++;
    if ({o_valid, o_pad, group_done, busy} !== 4'b0) begin
      errors++; $display("FAIL reset flags {valid,pad,gd,busy}: got %b expected 0000", {o_valid, o_pad, group_done, busy});
    end
    checks++;
    if (s_ready !== '0) begin errors++; $display("FAIL reset s_ready: got %b expected 0", s_ready); end
    checks++;
    if (o_src !== '0) begin errors++; $display("FAIL reset o_src: got %0d expected 0", o_src); end
    checks++;
    if (o_fidx !== '0) begin errors++; $display("FAIL reset o_fidx: got %0d expected 0", o_fidx); end
    reset = 1'b0;
    for (int k = 0; k < NS; k++) begin q[k].delete(); mq[k].delete(); end
    drive_src();
    cycle();
  endtask

  task automatic test_rr_group();
    int gd0;
    clear_obs();
    ready_mode = 0;
    gd0 = gd_cnt;
    for (int k = 0; k < NS; k++) load_frame(k, 3);
    model_run();
    run_until(200, "rr_group");
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL rr_group beat count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rr_group beat %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    if (obs.size() == 12) begin
      for (int f = 1; f < 4; f++) begin
        checks++;
        if (obs_cyc[3*f] !== obs_cyc[3*f-1] + 2) begin
          errors++; $display("FAIL rr_group gap before frame %0d: got %0d cycles expected 2", f, obs_cyc[3*f] - obs_cyc[3*f-1]);
        end
      end
      checks++;
      if (gd_cyc !== obs_cyc[11] + 1) begin errors++; $display("FAIL rr_group group_done cycle: got %0d expected %0d", gd_cyc, obs_cyc[11] + 1); end
    end
    checks++;
    if (gd_cnt - gd0 !== 1) begin errors++; $display("FAIL rr_group group_done pulses: got %0d expected 1", gd_cnt - gd0); end
  endtask

  task automatic test_flush_pad();
    int gd0, pads;
    clear_obs();
    ready_mode = 0;
    gd0 = gd_cnt;
    load_frame($urandom_range(0, NS - 1), $urandom_range(1, 4));
    model_run();
    run_until(100, "flush_pad frame");
    flush = 1'b1; cycle(); flush = 1'b0;
    model_flush();
    run_until(100, "flush_pad pads");
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL flush_pad beat %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    pads = 0;
    foreach (obs[i]) if (obs[i].pad) pads++;
    checks++;
    if (pads !== GRP - 1) begin errors++; $display("FAIL flush_pad pad beats: got %0d expected %0d", pads, GRP - 1); end
    checks++;
    if (gd_cnt - gd0 !== 1) begin errors++; $display("FAIL flush_pad group_done pulses: got %0d expected 1", gd_cnt - gd0); end
    checks++;
    if ({busy, o_fidx} !== '0) begin errors++; $display("FAIL flush_pad idle {busy,fidx}: got %b expected 0", {busy, o_fidx}); end
  endtask

  task automatic test_flush_midframe();
    int n;
    clear_obs();
    ready_mode = 2;
    o_ready = 1'b1;
    load_frame(1, 4);
    model_run();
    n = 0;
    while (obs.size() < 2 && n < 50) begin cycle(); n++; end
    flush = 1'b1; cycle(); flush = 1'b0;
    model_flush();
    run_until(200, "flush_midframe");
    checks++;
    if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL flush_midframe beat count: got %0d expected %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL flush_midframe beat %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
    if (obs.size() >= 4) begin
      checks++;
      if (first_pad_cyc !== obs_cyc[3] + 2) begin
        errors++; $display("FAIL flush_midframe first pad cycle: got %0d expected %0d", first_pad_cyc, obs_cyc[3] + 2);
      end
    end
  endtask

  task automatic test_flush_zero();
    int gd0;
    clear_obs();
    ready_mode = 0;
    gd0 = gd_cnt;
    flush = 1'b1; cycle(); flush = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flush_zero pending busy: got %b expected 1", busy); end
    cycle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_zero cleared busy: got %b expected 0", busy); end
    cycle(); cycle(); cycle();
    checks++;
    if (obs.size() !== 0 || gd_cnt !== gd0) begin
      errors++; $display("FAIL flush_zero activity: got %0d beats %0d pulses expected 0 0", obs.size(), gd_cnt - gd0);
    end
  endtask

  task automatic test_wrap_ptr();
    int idx;
    clear_obs();
    ready_mode = 0;
    load_frame(2, 2);
    model_run();
    run_until(100, "wrap_ptr first");
    checks++;
    if (o_src !== 2'd2) begin errors++; $display("FAIL wrap_ptr first grant: got %0d expected 2", o_src); end
    load_frame(2, 3);
    model_run();
    run_until(100, "wrap_ptr wrap");
    checks++;
    if (o_src !== 2'd2) begin errors++; $display("FAIL wrap_ptr wrapped grant: got %0d expected 2", o_src); end
    idx = obs.size();
    for (int k = 0; k < NS; k++) load_frame(k, $urandom_range(1, 4));
    model_run();
    run_until(200, "wrap_ptr all");
    checks++;
    if (obs.size() <= idx || obs[idx].src !== 2'd3) begin errors++; $display("FAIL wrap_ptr next grant after src2: got beats %0d expected src 3 first", obs.size() - idx); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL wrap_ptr beat %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int gd0, mgd0;
    ready_mode = 1;
    for (int it = 0; it < 8; it++) begin
      clear_obs();
      gd0 = gd_cnt;
      mgd0 = m_gd;
      for (int k = 0; k < NS; k++) begin
        int nf;
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) load_frame(k, $urandom_range(1, 4));
      end
      model_run();
      run_until(400, "random");
      if ($urandom_range(0, 1) == 1) begin
        flush = 1'b1; cycle(); flush = 1'b0;
        model_flush();
        run_until(100, "random flush");
      end
      checks++;
      if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL random it %0d beat count: got %0d expected %0d", it, obs.size(), exp_q.size()); end
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL random it %0d beat %0d: got %h expected %h", it, i, obs[i], exp_q[i]); end
      end
      checks++;
      if (gd_cnt - gd0 !== m_gd - mgd0) begin errors++; $display("FAIL random it %0d group_done pulses: got %0d expected %0d", it, gd_cnt - gd0, m_gd - mgd0); end
      checks++;
      if (o_fidx !== THW'(m_fcnt)) begin errors++; $display("FAIL random it %0d o_fidx: got %0d expected %0d", it, o_fidx, m_fcnt); end
    end
  endtask

  task automatic test_reset_midframe();
    int n, gd0;
    clear_obs();
    ready_mode = 0;
    o_ready = 1'b1;
    gd0 = gd_cnt;
    load_frame(1, 4);
    n = 0;
    while (obs.size() < 1 && n < 50) begin cycle(); n++; end
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL reset_midframe beat 2 valid: got %b expected 1", o_valid); end
    reset = 1'b1;
    cycle();
    checks++;
    if ({o_valid, busy, group_done} !== 3'b0) begin errors++; $display("FAIL reset_midframe {valid,busy,gd}: got %b expected 000", {o_valid, busy, group_done}); end
    checks++;
    if (s_ready !== '0) begin errors++; $display("FAIL reset_midframe s_ready: got %b expected 0", s_ready); end
    checks++;
    if (o_fidx !== '0) begin errors++; $display("FAIL reset_midframe o_fidx: got %0d expected 0", o_fidx); end
    reset = 1'b0;
    for (int k = 0; k < NS; k++) begin q[k].delete(); mq[k].delete(); end
    drive_src();
    m_ptr = 0; m_fcnt = 0; m_src = 0;
    cycle(); cycle(); cycle();
    checks++;
    if (gd_cnt !== gd0) begin errors++; $display("FAIL reset_midframe group_done pulses: got %0d expected 0", gd_cnt - gd0); end
    clear_obs();
    load_frame(3, 2);
    model_run();
    run_until(100, "reset_midframe recover");
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL reset_midframe recover beat %0d: got %h expected %h", i, obs[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_rr_group();
    test_flush_pad();
    test_flush_midframe();
    test_flush_zero();
    test_wrap_ptr();
    test_random();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
